branch_resolve: RTL
===================

# branch_resolve

Branch resolution stage sitting directly downstream of the flag register. It consumes the Z/V/N flag outputs, which already include same-cycle write bypass, and evaluates a branch's 3-bit condition code. It then produces a registered one-cycle redirect/flush to fetch and decode. When a flag-setting instruction is still in flight, it holds decode with a stall until the flags are architecturally valid.

## Interface
- PC_W, 16: PC and target width
- IMM_W, 9: branch immediate width, word offset
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- br_valid  in  1  branch instruction present in decode
- br_reg  in  1  1 = BR (target from register), 0 = B (PC-relative)
- cond  in  3  condition code
- imm  in  IMM_W  signed word offset
- pc_plus2  in  PC_W  address of the instruction after the branch
- rs_data  in  PC_W  register target for BR
- flags_pending  in  1  a flag-writing instruction has not yet written the flag register
- Z, V, N  in  1 each  flag register outputs
- stall  out  1  hold decode and fetch (combinational)
- redirect  out  1  one-cycle pulse: load redirect_pc into PC
- flush  out  1  one-cycle pulse: squash the instruction in decode
- redirect_pc  out  PC_W  branch target, valid while redirect = 1
- resolved  out  1  one-cycle pulse: a branch finished resolving
- taken  out  1  outcome of the last resolution, valid while resolved = 1

## Operation
- Conditions: 000 Z=0; 001 Z=1; 010 Z=0 & N=0; 011 N=1; 100 Z=1 | (Z=0 & N=0); 101 N=1 | Z=1; 110 V=1; 111 always.
- Target:
  - B: pc_plus2 + (sign_extend(imm) << 1), truncated to PC_W, wraps modulo 2^PC_W.
  - BR: rs_data.
- FSM states: IDLE, WAIT_FLAGS, REDIRECT.
- IDLE:
  - br_valid & (!flags_pending | cond=111): evaluate now.
    - Taken: go to REDIRECT.
    - Not taken: pulse resolved with taken=0 and stay in IDLE.
  - br_valid & flags_pending & cond!=111: capture br_reg, cond, imm, pc_plus2, rs_data; go to WAIT_FLAGS.
- WAIT_FLAGS:
  - Only the captured fields and live Z/V/N are used.
  - The first cycle with flags_pending=0: evaluate, then go to REDIRECT (taken) or IDLE (not taken, resolved pulse).
- REDIRECT:
  - redirect=1, flush=1, resolved=1, taken=1 for exactly one cycle.
  - br_valid is ignored in this cycle because it is wrong-path.
  - Next state is IDLE.
- stall = (state=IDLE & br_valid & flags_pending & cond!=111) | (state=WAIT_FLAGS & flags_pending). stall is 0 in REDIRECT.
- Reset:
  - state = IDLE.
  - redirect, flush, resolved, taken = 0; redirect_pc = 0; stall = 0.
  - Captured fields are cleared.
- Reset during WAIT_FLAGS or REDIRECT: the pending branch is dropped and no redirect is issued afterwards.

## Timing
- Resolution cycle: the cycle in which evaluation happens (IDLE with flags ready, or the first WAIT_FLAGS cycle with flags_pending=0).
- redirect, flush, resolved, taken and redirect_pc are all registered. They appear one cycle after the resolution cycle.
- Taken branch with flags ready: branch in decode at cycle t; redirect at t+1; fetch from target at t+2.
- Taken branch with flags pending: a branch with flags_pending high for k cycles sees stall high for k cycles; redirect is asserted k+1 cycles after the branch arrives.
- Not-taken resolutions produce only the resolved pulse: no redirect, no flush.
- Flag writes in the same cycle as evaluation: the flag register bypass makes the new value visible, so evaluation uses it.
- redirect_pc holds its last value when redirect=0.

## Configuration
- BRANCH_STATS_EN, when defined, adds:
  - out stat_taken [15:0] and out stat_not_taken [15:0]: saturating counters (stop at 0xFFFF), incremented on each resolved pulse by outcome.
  - out stat_stall_cycles [15:0]: saturating count of cycles with stall=1.
  - All counters clear on rst.
- When undefined, these ports and counters do not exist, and the remaining behaviour is identical.

## Test plan
- cond=001, Z=1, flags_pending=0, br_reg=0, pc_plus2=0x0010, imm=0x004 -> next cycle redirect=1, flush=1, redirect_pc=0x0018, stall never asserted.
- cond=000, Z=1 -> resolved=1, taken=0, redirect=0, flush=0; state remains IDLE.
- pc_plus2=0x0002, imm=0x1FE (-2) -> redirect_pc=0xFFFE (wrap); pc_plus2=0xFFFE, imm=0x001 -> 0x0000.
- cond=011, flags_pending=1 for 3 cycles and then N=1 -> stall=1 for exactly 3 cycles, redirect 1 cycle after flags_pending falls. cond=111 with flags_pending=1 -> no stall, immediate redirect.
- br_reg=1, rs_data=0xABCD, cond=110, V=1 -> redirect_pc=0xABCD. A second br_valid in the REDIRECT cycle is ignored, with no extra resolved pulse.
- rst asserted during WAIT_FLAGS -> all outputs 0 next cycle, and no redirect after rst deasserts even when flags_pending=0. With BRANCH_STATS_EN, counters read 0.

Source files
------------

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - branch condition evaluation, flag-wait stall and registered redirect/flush; optional counters under BRANCH_STATS_EN
module branch_resolve #(
  parameter int PC_W  = 16,
  parameter int IMM_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br_valid,
  input  logic             br_reg,
  input  logic [2:0]       cond,
  input  logic [IMM_W-1:0] imm,
  input  logic [PC_W-1:0]  pc_plus2,
  input  logic [PC_W-1:0]  rs_data,
  input  logic             flags_pending,
  input  logic             Z,
  input  logic             V,
  input  logic             N,
  output logic             stall,
  output logic             redirect,
  output logic             flush,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             resolved,
`ifdef BRANCH_STATS_EN
  output logic [15:0]      stat_taken,
  output logic [15:0]      stat_not_taken,
  output logic [15:0]      stat_stall_cycles,
`endif
  output logic             taken
);

  localparam logic [2:0] COND_ALWAYS = 3'b111;

  typedef enum logic [1:0] {IDLE, WAIT_FLAGS, REDIRECT} state_t;

  state_t            state_q, state_d;
  logic              br_reg_q, br_reg_d;
  logic [2:0]        cond_q, cond_d;
  logic [IMM_W-1:0]  imm_q, imm_d;
  logic [PC_W-1:0]   pc_plus2_q, pc_plus2_d;
  logic [PC_W-1:0]   rs_data_q, rs_data_d;
  logic              redirect_q, redirect_d;
  logic              flush_q, flush_d;
  logic              resolved_q, resolved_d;
  logic              taken_q, taken_d;
  logic [PC_W-1:0]   redirect_pc_q, redirect_pc_d;
  logic              stall_c;

  logic              eval;
  logic              use_br_reg;
  logic [2:0]        use_cond;
  logic [IMM_W-1:0]  use_imm;
  logic [PC_W-1:0]   use_pc;
  logic [PC_W-1:0]   use_rs;
  logic [PC_W-1:0]   imm_ext;
  logic [PC_W-1:0]   target;

  function automatic logic cond_met(input logic [2:0] c, input logic z, input logic v, input logic n);
    case (c)
      3'b000:  cond_met = !z;
      3'b001:  cond_met = z;
      3'b010:  cond_met = !z && !n;
      3'b011:  cond_met = n;
      3'b100:  cond_met = z || (!z && !n);
      3'b101:  cond_met = n || z;
      3'b110:  cond_met = v;
      default: cond_met = 1'b1;
    endcase
  endfunction

  // Next-state, capture, stall and registered-output computation.
  always_comb begin
    state_d       = state_q;
    br_reg_d      = br_reg_q;
    cond_d        = cond_q;
    imm_d         = imm_q;
    pc_plus2_d    = pc_plus2_q;
    rs_data_d     = rs_data_q;
    redirect_d    = 1'b0;
    flush_d       = 1'b0;
    resolved_d    = 1'b0;
    taken_d       = 1'b0;
    redirect_pc_d = redirect_pc_q;
    stall_c       = 1'b0;
    eval          = 1'b0;
    use_br_reg    = br_reg;
    use_cond      = cond;
    use_imm       = imm;
    use_pc        = pc_plus2;
    use_rs        = rs_data;

    case (state_q)
      IDLE: begin
        if (br_valid) begin
          if (!flags_pending || cond == COND_ALWAYS) begin
            eval = 1'b1;
          end else begin
            br_reg_d   = br_reg;
            cond_d     = cond;
            imm_d      = imm;
            pc_plus2_d = pc_plus2;
            rs_data_d  = rs_data;
            stall_c    = 1'b1;
            state_d    = WAIT_FLAGS;
          end
        end
      end
      WAIT_FLAGS: begin
        // Decode is frozen; only the captured branch and live flags matter.
        use_br_reg = br_reg_q;
        use_cond   = cond_q;
        use_imm    = imm_q;
        use_pc     = pc_plus2_q;
        use_rs     = rs_data_q;
        if (flags_pending) begin
          stall_c = 1'b1;
        end else begin
          eval = 1'b1;
        end
      end
      REDIRECT: begin
        // br_valid here is the wrong-path instruction being flushed.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    imm_ext = {{(PC_W - IMM_W){use_imm[IMM_W-1]}}, use_imm};
    target  = use_br_reg ? use_rs : (use_pc + {imm_ext[PC_W-2:0], 1'b0});

    if (eval) begin
      resolved_d = 1'b1;
      if (cond_met(use_cond, Z, V, N)) begin
        taken_d       = 1'b1;
        redirect_d    = 1'b1;
        flush_d       = 1'b1;
        redirect_pc_d = target;
        state_d       = REDIRECT;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // State, captured branch fields and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      br_reg_q      <= 1'b0;
      cond_q        <= 3'b000;
      imm_q         <= '0;
      pc_plus2_q    <= '0;
      rs_data_q     <= '0;
      redirect_q    <= 1'b0;
      flush_q       <= 1'b0;
      resolved_q    <= 1'b0;
      taken_q       <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      br_reg_q      <= br_reg_d;
      cond_q        <= cond_d;
      imm_q         <= imm_d;
      pc_plus2_q    <= pc_plus2_d;
      rs_data_q     <= rs_data_d;
      redirect_q    <= redirect_d;
      flush_q       <= flush_d;
      resolved_q    <= resolved_d;
      taken_q       <= taken_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign stall       = stall_c && !rst;
  assign redirect    = redirect_q;
  assign flush       = flush_q;
  assign resolved    = resolved_q;
  assign taken       = taken_q;
  assign redirect_pc = redirect_pc_q;

`ifdef BRANCH_STATS_EN
  logic [15:0] stat_taken_q, stat_taken_d;
  logic [15:0] stat_not_taken_q, stat_not_taken_d;
  logic [15:0] stat_stall_q, stat_stall_d;

  // Saturating counters for resolution outcomes and stall cycles.
  always_comb begin
    stat_taken_d     = stat_taken_q;
    stat_not_taken_d = stat_not_taken_q;
    stat_stall_d     = stat_stall_q;
    if (resolved_q && taken_q && stat_taken_q != 16'hFFFF) begin
      stat_taken_d = stat_taken_q + 16'd1;
    end
    if (resolved_q && !taken_q && stat_not_taken_q != 16'hFFFF) begin
      stat_not_taken_d = stat_not_taken_q + 16'd1;
    end
    if (stall && stat_stall_q != 16'hFFFF) begin
      stat_stall_d = stat_stall_q + 16'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_taken_q     <= '0;
      stat_not_taken_q <= '0;
      stat_stall_q     <= '0;
    end else begin
      stat_taken_q     <= stat_taken_d;
      stat_not_taken_q <= stat_not_taken_d;
      stat_stall_q     <= stat_stall_d;
    end
  end

  assign stat_taken        = stat_taken_q;
  assign stat_not_taken    = stat_not_taken_q;
  assign stat_stall_cycles = stat_stall_q;
`endif

endmodule
